// File: rtl/mio_bridge.sv
// CPU-to-memory/IO bridge: routes CPU accesses to a synchronous RAM or a req/ack peripheral port.
// Defining MIO_TIMEOUT_EN adds a 16-cycle IO timeout that completes the access with bus_err.
module mio_bridge (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_mio,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        mio_ready,
  output logic        bus_err,
  output logic        ram_en,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [3:0]  io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  typedef enum logic [1:0] {IDLE, RAM_RD, IO_WAIT, DONE} state_t;

  state_t state, state_next;
  logic   is_io;
  logic   is_write;
  logic   accept;
  logic   io_done;
  logic   io_timeout;
  logic   unused_addr;

  assign is_io       = (addr[31:28] == 4'hE) || (addr[31:28] == 4'hF);
  assign is_write    = mem_w;
  assign accept      = (state == IDLE) && cpu_mio && (mem_r || mem_w);
  assign io_done     = (state == IO_WAIT) && io_ack;
  assign ram_addr    = addr[11:2];
  assign ram_wdata   = cpu_wdata;
  assign unused_addr = ^{addr[27:12], addr[1:0]};

`ifdef MIO_TIMEOUT_EN
  logic [3:0] timeout_cnt;
  logic       err_q;

  // Timeout fires on the 16th unacknowledged IO_WAIT cycle; io_ack in that cycle takes priority.
  assign io_timeout = (state == IO_WAIT) && !io_ack && (timeout_cnt == 4'hF);
  assign bus_err    = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      err_q <= io_timeout;
      if (accept && is_io)
        timeout_cnt <= 4'd0;
      else if ((state == IO_WAIT) && !io_ack)
        timeout_cnt <= timeout_cnt + 4'd1;
    end
  end
`else
  assign io_timeout = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_io)
            state_next = IO_WAIT;
          else if (is_write)
            state_next = DONE;
          else
            state_next = RAM_RD;
        end
      end
      RAM_RD:  state_next = DONE;
      IO_WAIT: if (io_done || io_timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    mio_ready = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !is_io) begin
          ram_en = 1'b1;
          ram_we = is_write;
        end
      end
      DONE:    mio_ready = 1'b1;
      default: ;
    endcase
  end

  // Read data only moves on read completion, so writes and idle cycles leave it intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cpu_rdata <= 32'd0;
    else if (state == RAM_RD)
      cpu_rdata <= ram_rdata;
    else if (io_done && !io_we)
      cpu_rdata <= io_rdata;
    else if (io_timeout && !io_we)
      cpu_rdata <= 32'hDEADBEEF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 4'd0;
      io_wdata <= 32'd0;
    end else if (accept && is_io) begin
      io_req   <= 1'b1;
      io_we    <= is_write;
      io_addr  <= addr[5:2];
      io_wdata <= cpu_wdata;
    end else if (io_done || io_timeout) begin
      io_req <= 1'b0;
    end
  end

endmodule
